row_mac_engine: RTL and testbench

ROW_MAC_ENGINE -- requirements
Module: row_mac_engine

---
 rtl/mat_pkg.sv | 16 +
 rtl/row_mac_engine_if.sv | 30 +++
 rtl/mac_column.sv | 51 +++++
 rtl/row_mac_engine.sv | 106 ++++++++++
 tb/tb_row_mac_engine.sv | 299 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/mat_pkg.sv
// Shared types and sizing helpers for the row multiply-accumulate engine.
package mat_pkg;

  // Row-engine control states.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DONE  = 2'd2
  } state_t;

  // Result width: a full product plus enough headroom to sum n of them.
  function automatic int acc_bits(input int bits, input int n);
    return 2 * bits + $clog2(n);
  endfunction

endpackage

// File: rtl/row_mac_engine_if.sv
// Streaming interface of the row engine: A-row beats in, row results out.
interface row_mac_engine_if
  import mat_pkg::*;
#(
  parameter int BITS     = 8,
  parameter int N        = 8,
  parameter int WIDTH    = 4,
  parameter int ACC_BITS = acc_bits(BITS, N)
);

  logic                       a_valid;
  logic                       a_ready;
  logic [WIDTH-1:0][BITS-1:0] a_in;
  logic                       out_valid;
  logic                       out_ready;
  logic [N-1:0][ACC_BITS-1:0] out;

  // Producer of A beats and consumer of results.
  modport master (
    output a_valid, a_in, out_ready,
    input  a_ready, out_valid, out
  );

  // The engine itself.
  modport slave (
    input  a_valid, a_in, out_ready,
    output a_ready, out_valid, out
  );

endinterface

// File: rtl/mac_column.sv
// One output column: WIDTH multipliers, an adder tree and the column accumulator.
module mac_column
  import mat_pkg::*;
#(
  parameter int BITS     = 8,
  parameter int WIDTH    = 4,
  parameter int SIGNED   = 0,
  parameter int ACC_BITS = 2 * BITS + 2
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       clear,
  input  logic                       load,
  input  logic                       accum,
  input  logic [WIDTH-1:0][BITS-1:0] a_chunk,
  input  logic [WIDTH-1:0][BITS-1:0] b_chunk,
  output logic [ACC_BITS-1:0]        acc
);

  logic [ACC_BITS-1:0] partial;

  // Widen an operand to the result width; the low ACC_BITS of the product of
  // two widened operands are exact for both signed and unsigned data.
  function automatic logic [ACC_BITS-1:0] extend(input logic [BITS-1:0] v);
    return {{(ACC_BITS - BITS){(SIGNED != 0) && v[BITS-1]}}, v};
  endfunction

  // Dot product of this beat's A chunk with the matching slice of the column.
  always_comb begin
    // NOTE: assign the default before the loop so no path leaves partial unassigned (no latch).
    partial = '0;
    for (int j = 0; j < WIDTH; j++) begin
      partial = partial + extend(a_chunk[j]) * extend(b_chunk[j]);
    end
  end

  // Accumulator: clear beats load, load (first beat of a row) beats add.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: non-blocking assignments so every register samples pre-edge values.
    if (!rst_n) begin
      acc <= '0;
    end else if (clear) begin
      acc <= '0;
    end else if (load) begin
      acc <= partial;
    end else if (accum) begin
      acc <= acc + partial;
    end
  end

endmodule

// File: rtl/row_mac_engine.sv
// Computes one row of C = A * B per transaction: A arrives WIDTH elements per
// beat, B is held on b_in, and the N column sums are presented with valid/ready.
module row_mac_engine
  import mat_pkg::*;
#(
  parameter int BITS   = 8,
  parameter int N      = 8,
  parameter int WIDTH  = 4,
  parameter int SIGNED = 0
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            flush,
  input  logic [N-1:0][N-1:0][BITS-1:0]   b_in,
  output logic                            busy,
  row_mac_engine_if.slave                 bus
);

  localparam int ACC_BITS = acc_bits(BITS, N);
  localparam int BEATS    = N / WIDTH;
  localparam int CNT_W    = (BEATS > 1) ? $clog2(BEATS) : 1;

  state_t                     state;
  state_t                     state_nxt;
  logic [CNT_W-1:0]           beat_cnt;
  logic                       accept;
  logic                       last_beat;
  logic                       load_en;
  logic                       accum_en;
  logic [N-1:0][ACC_BITS-1:0] acc;

  assign bus.a_ready   = (state != DONE);
  assign accept        = bus.a_valid && bus.a_ready;
  // From IDLE the incoming beat is the first one, so it is last only for single-beat rows.
  assign last_beat     = (state == IDLE) ? (BEATS == 1) : (beat_cnt == CNT_W'(BEATS - 1));
  assign load_en       = accept && !flush && (state == IDLE);
  assign accum_en      = accept && !flush && (state == ACCUM);
  assign bus.out_valid = (state == DONE);
  assign bus.out       = acc;
  assign busy          = (state != IDLE);

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic; flush overrides any beat or output handshake.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = last_beat ? DONE : ACCUM;
      ACCUM:   if (accept && last_beat) state_nxt = DONE;
      DONE:    if (bus.out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
    if (flush) state_nxt = IDLE;
  end

  // Beat counter: selects which B rows pair with the current A chunk.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      beat_cnt <= '0;
    end else if (flush) begin
      beat_cnt <= '0;
    end else if (accept) begin
      beat_cnt <= last_beat ? '0 : beat_cnt + CNT_W'(1);
    end
  end

  for (genvar c = 0; c < N; c++) begin : g_col
    logic [WIDTH-1:0][BITS-1:0] b_chunk;

    // Pick B[WIDTH*beat_cnt + j][c] for each lane j.
    always_comb begin
      b_chunk = '0;
      for (int k = 0; k < BEATS; k++) begin
        if (beat_cnt == CNT_W'(k)) begin
          for (int j = 0; j < WIDTH; j++) begin
            b_chunk[j] = b_in[k * WIDTH + j][c];
          end
        end
      end
    end

    mac_column #(
      .BITS     (BITS),
      .WIDTH    (WIDTH),
      .SIGNED   (SIGNED),
      .ACC_BITS (ACC_BITS)
    ) u_col (
      .clk     (clk),
      .rst_n   (rst_n),
      .clear   (flush),
      .load    (load_en),
      .accum   (accum_en),
      .a_chunk (bus.a_in),
      .b_chunk (b_chunk),
      .acc     (acc[c])
    );
  end

endmodule

// File: tb/tb_row_mac_engine.sv
// Bench for row_mac_engine: an unsigned and a signed instance see identical
// stimulus; each is compared with an arithmetic row-times-matrix model.
module tb_row_mac_engine;

  localparam int BITS  = 8;
  localparam int N     = 4;
  localparam int WIDTH = 2;
  localparam int ACC   = 18;

  typedef logic [N-1:0][ACC-1:0] row_t;

  logic                          clk       = 1'b0;
  logic                          rst_n     = 1'b0;
  logic                          flush     = 1'b0;
  logic                          a_valid   = 1'b0;
  logic                          out_ready = 1'b1;
  logic [WIDTH-1:0][BITS-1:0]    a_in      = '0;
  logic [N-1:0][N-1:0][BITS-1:0] b_mat     = '0;
  logic                          busy_u;
  logic                          busy_s;
  logic [BITS-1:0]               a_row [N];
  int                            checks = 0;
  int                            errors = 0;

  row_mac_engine_if #(.BITS(BITS), .N(N), .WIDTH(WIDTH)) bus_u ();
  row_mac_engine_if #(.BITS(BITS), .N(N), .WIDTH(WIDTH)) bus_s ();

  assign bus_u.a_valid   = a_valid;
  assign bus_u.a_in      = a_in;
  assign bus_u.out_ready = out_ready;
  assign bus_s.a_valid   = a_valid;
  assign bus_s.a_in      = a_in;
  assign bus_s.out_ready = out_ready;

  row_mac_engine #(.BITS(BITS), .N(N), .WIDTH(WIDTH), .SIGNED(0)) dut_u (
    .clk(clk), .rst_n(rst_n), .flush(flush), .b_in(b_mat), .busy(busy_u), .bus(bus_u)
  );

  row_mac_engine #(.BITS(BITS), .N(N), .WIDTH(WIDTH), .SIGNED(1)) dut_s (
    .clk(clk), .rst_n(rst_n), .flush(flush), .b_in(b_mat), .busy(busy_s), .bus(bus_s)
  );

  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  function automatic int elem(input logic [BITS-1:0] v, input bit sgn);
    return sgn ? int'($signed(v)) : int'(v);
  endfunction

  function automatic row_t model_row(input bit sgn);
    row_t r;
    for (int c = 0; c < N; c++) begin
      int s = 0;
      for (int k = 0; k < N; k++) s += elem(a_row[k], sgn) * elem(b_mat[k][c], sgn);
      r[c] = ACC'(s);
    end
    return r;
  endfunction

  // ---------------- stimulus helpers ----------------
  task automatic randomize_row();
    for (int k = 0; k < N; k++) a_row[k] = BITS'($urandom);
  endtask

  task automatic randomize_b();
    b_mat = {$urandom, $urandom, $urandom, $urandom};
  endtask

  // Sends a_row as N/WIDTH beats with `gap` idle cycles between beats; returns
  // on the falling edge right after the last beat was taken.
  task automatic drive_row(input int gap);
    for (int b = 0; b < N / WIDTH; b++) begin
      for (int g = 0; g < ((b > 0) ? gap : 0); g++) begin
        @(negedge clk);
        a_valid = 1'b0;
      end
      @(negedge clk);
      a_valid = 1'b1;
      for (int j = 0; j < WIDTH; j++) a_in[j] = a_row[b * WIDTH + j];
    end
    @(negedge clk);
    a_valid = 1'b0;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if (bus_u.out_valid !== 1'b0 || bus_s.out_valid !== 1'b0) begin
      errors++; $display("FAIL reset_out_valid: got %b/%b expected 0/0", bus_u.out_valid, bus_s.out_valid);
    end
    checks++;
    if (busy_u !== 1'b0 || busy_s !== 1'b0) begin
      errors++; $display("FAIL reset_busy: got %b/%b expected 0/0", busy_u, busy_s);
    end
    checks++;
    if (bus_u.a_ready !== 1'b1 || bus_s.a_ready !== 1'b1) begin
      errors++; $display("FAIL reset_a_ready: got %b/%b expected 1/1", bus_u.a_ready, bus_s.a_ready);
    end
    checks++;
    if (bus_u.out !== row_t'(0) || bus_s.out !== row_t'(0)) begin
      errors++; $display("FAIL reset_out: got %h/%h expected 0", bus_u.out, bus_s.out);
    end
  endtask

  task automatic test_identity();
    row_t exp = {18'd4, 18'd3, 18'd2, 18'd1};
    b_mat = '0;
    for (int k = 0; k < N; k++) b_mat[k][k] = 8'd1;
    a_row = '{8'd1, 8'd2, 8'd3, 8'd4};
    drive_row(0);
    checks++;
    if (bus_u.out_valid !== 1'b1 || bus_s.out_valid !== 1'b1) begin
      errors++; $display("FAIL identity_latency: out_valid %b/%b expected 1/1", bus_u.out_valid, bus_s.out_valid);
    end
    checks++;
    if (bus_u.out !== exp || bus_s.out !== exp) begin
      errors++; $display("FAIL identity_out: got %h/%h expected %h", bus_u.out, bus_s.out, exp);
    end
    @(negedge clk);
    checks++;
    if (bus_u.out_valid !== 1'b0 || busy_u !== 1'b0 || bus_s.out_valid !== 1'b0 || busy_s !== 1'b0) begin
      errors++; $display("FAIL identity_release: valid %b/%b busy %b/%b expected all 0",
                         bus_u.out_valid, bus_s.out_valid, busy_u, busy_s);
    end
  endtask

  task automatic test_extremes();
    for (int t = 0; t < 2; t++) begin
      logic [BITS-1:0] v     = (t == 0) ? 8'hFF : 8'h80;
      logic [ACC-1:0]  exp_u = (t == 0) ? 18'd260100 : 18'd65536;
      logic [ACC-1:0]  exp_s = (t == 0) ? 18'd4 : 18'd65536;
      b_mat = {(N * N){v}};
      for (int k = 0; k < N; k++) a_row[k] = v;
      drive_row(0);
      checks++;
      if (bus_u.out !== {N{exp_u}}) begin
        errors++; $display("FAIL extreme_unsigned[%0d]: got %h expected %h", t, bus_u.out, {N{exp_u}});
      end
      checks++;
      if (bus_s.out !== {N{exp_s}}) begin
        errors++; $display("FAIL extreme_signed[%0d]: got %h expected %h", t, bus_s.out, {N{exp_s}});
      end
      @(negedge clk);
    end
  endtask

  task automatic test_stall();
    row_t exp_u;
    row_t exp_s;
    randomize_row();
    randomize_b();
    exp_u = model_row(1'b0);
    exp_s = model_row(1'b1);
    out_ready = 1'b0;
    drive_row(0);
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (bus_u.out_valid !== 1'b1 || bus_s.out_valid !== 1'b1 || bus_u.a_ready !== 1'b0 || bus_s.a_ready !== 1'b0) begin
        errors++; $display("FAIL stall_ctrl[%0d]: valid %b/%b a_ready %b/%b expected 1/1 0/0",
                           i, bus_u.out_valid, bus_s.out_valid, bus_u.a_ready, bus_s.a_ready);
      end
      checks++;
      if (bus_u.out !== exp_u || bus_s.out !== exp_s) begin
        errors++; $display("FAIL stall_out[%0d]: got %h/%h expected %h/%h", i, bus_u.out, bus_s.out, exp_u, exp_s);
      end
      a_valid = 1'b1;
      a_in    = WIDTH * BITS'($urandom);
      @(negedge clk);
    end
    a_valid   = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    checks++;
    if (bus_u.out_valid !== 1'b0 || bus_s.out_valid !== 1'b0 || busy_u !== 1'b0 || busy_s !== 1'b0) begin
      errors++; $display("FAIL stall_release: valid %b/%b busy %b/%b expected all 0",
                         bus_u.out_valid, bus_s.out_valid, busy_u, busy_s);
    end
    checks++;
    if (bus_u.out !== exp_u || bus_s.out !== exp_s) begin
      errors++; $display("FAIL stall_hold_idle: got %h/%h expected %h/%h", bus_u.out, bus_s.out, exp_u, exp_s);
    end
  endtask

  task automatic test_flush();
    b_mat = {(N * N){8'd2}};
    @(negedge clk);
    a_valid = 1'b1;
    a_in    = WIDTH * BITS'($urandom);
    @(negedge clk);
    checks++;
    if (busy_u !== 1'b1 || busy_s !== 1'b1) begin
      errors++; $display("FAIL flush_busy_before: got %b/%b expected 1/1", busy_u, busy_s);
    end
    flush   = 1'b1;
    a_in    = WIDTH * BITS'($urandom);
    @(negedge clk);
    flush   = 1'b0;
    a_valid = 1'b0;
    checks++;
    if (busy_u !== 1'b0 || busy_s !== 1'b0 || bus_u.out_valid !== 1'b0 || bus_s.out_valid !== 1'b0) begin
      errors++; $display("FAIL flush_state: busy %b/%b valid %b/%b expected all 0",
                         busy_u, busy_s, bus_u.out_valid, bus_s.out_valid);
    end
    checks++;
    if (bus_u.out !== row_t'(0) || bus_s.out !== row_t'(0)) begin
      errors++; $display("FAIL flush_clear: got %h/%h expected 0", bus_u.out, bus_s.out);
    end
    for (int k = 0; k < N; k++) a_row[k] = 8'd1;
    drive_row(0);
    checks++;
    if (bus_u.out !== {N{18'd8}} || bus_s.out !== {N{18'd8}}) begin
      errors++; $display("FAIL flush_next_row: got %h/%h expected %h", bus_u.out, bus_s.out, {N{18'd8}});
    end
    @(negedge clk);
  endtask

  task automatic test_async_reset();
    randomize_b();
    @(negedge clk);
    a_valid = 1'b1;
    a_in    = WIDTH * BITS'($urandom);
    @(negedge clk);
    a_valid = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (busy_u !== 1'b0 || busy_s !== 1'b0 || bus_u.out_valid !== 1'b0 || bus_s.out_valid !== 1'b0) begin
      errors++; $display("FAIL async_reset: busy %b/%b valid %b/%b expected all 0",
                         busy_u, busy_s, bus_u.out_valid, bus_s.out_valid);
    end
    @(negedge clk);
    rst_n = 1'b1;
    randomize_row();
    drive_row(0);
    checks++;
    if (bus_u.out !== model_row(1'b0) || bus_s.out !== model_row(1'b1)) begin
      errors++; $display("FAIL async_reset_next_row: got %h/%h expected %h/%h",
                         bus_u.out, bus_s.out, model_row(1'b0), model_row(1'b1));
    end
    @(negedge clk);
  endtask

  task automatic test_gaps();
    randomize_row();
    randomize_b();
    for (int pass = 0; pass < 2; pass++) begin
      drive_row((pass == 0) ? 3 : 0);
      checks++;
      if (bus_u.out_valid !== 1'b1 || bus_s.out_valid !== 1'b1) begin
        errors++; $display("FAIL gaps_valid[%0d]: got %b/%b expected 1/1", pass, bus_u.out_valid, bus_s.out_valid);
      end
      checks++;
      if (bus_u.out !== model_row(1'b0) || bus_s.out !== model_row(1'b1)) begin
        errors++; $display("FAIL gaps_out[%0d]: got %h/%h expected %h/%h",
                           pass, bus_u.out, bus_s.out, model_row(1'b0), model_row(1'b1));
      end
      @(negedge clk);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 12; i++) begin
      randomize_row();
      randomize_b();
      drive_row(int'($urandom_range(0, 3)));
      checks++;
      if (bus_u.out !== model_row(1'b0) || bus_s.out !== model_row(1'b1)) begin
        errors++; $display("FAIL random_out[%0d]: got %h/%h expected %h/%h",
                           i, bus_u.out, bus_s.out, model_row(1'b0), model_row(1'b1));
      end
      @(negedge clk);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_identity();
    test_extremes();
    test_stall();
    test_flush();
    test_async_reset();
    test_gaps();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
